// File: rtl/serial_add_ctrl_if.sv
// Start/operand request and result bundle for the bit-serial add/subtract sequencer.
// The master drives the request side; the slave (the sequencer) drives status and results.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell walks the operands LSB first,
// holding the carry in a flip-flop, and reports sum/cout/ovf with a one-cycle done pulse.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_add_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sumf;
    logic             carryf;

    full_adder u_fa (
        .a_i (a_sr_q[0]),
        .b_i (b_sr_q[0]),
        .c_i (carry_q),
        .s_o (sumf),
        .c_o (carryf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    // Subtraction is a + ~b + 1: B is inverted on capture and the carry FF is preset to 1.
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sr_d  = bus.a;
                    b_sr_d  = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_sr_d = {sumf, sum_sr_q[WIDTH-1:1]};
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                carry_d  = carryf;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = {sumf, sum_sr_q[WIDTH-1:1]};
                    cout_d  = carryf;
                    ovf_d   = carry_q ^ carryf;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomised scoreboard bench for serial_add_ctrl: an arithmetic reference model queues the
// expected result on every accepted request and a monitor checks each done pulse against it.
module tb_serial_add_ctrl;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } result_t;

    logic    clk;
    logic    rst_n;
    int      compared;
    int      mismatched;
    result_t expQ[$];
    int      phase;
    logic    prevDone;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Plain modular and signed arithmetic; no bit-level stepping.
    function automatic result_t refModel(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        result_t r;
        int unsigned full;
        int sa, sb, res;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            full = int'(a) + (1 << W) - int'(b);
            res  = sa - sb;
        end else begin
            full = int'(a) + int'(b);
            res  = sa + sb;
        end
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (res > (1 << (W - 1)) - 1) || (res < -(1 << (W - 1)));
        return r;
    endfunction

    // Timing model: phase 0 idle, 1..W busy, W+1 done.
    always @(posedge clk) begin
        if (!rst_n) begin
            phase = 0;
            expQ.delete();
        end else if (phase == 0) begin
            if (bus.start) begin
                expQ.push_back(refModel(bus.a, bus.b, bus.sub));
                phase = 1;
            end
        end else if (phase < W + 1) begin
            phase = phase + 1;
        end else begin
            phase = 0;
        end
    end

    initial prevDone = 1'b0;
    always @(negedge clk) begin
        result_t e;
        checkOutput("busy", 32'(bus.busy), 32'((phase >= 1) && (phase <= W)));
        checkOutput("done", 32'(bus.done), 32'(phase == W + 1));
        if (bus.done === 1'b1) begin
            checkOutput("doneWidth", 32'(prevDone), 32'(0));
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL scoreboard: done with no expected result at %0t", $time);
            end else begin
                e = expQ.pop_front();
                checkOutput("sum", 32'(bus.sum), 32'(e.sum));
                checkOutput("cout", 32'(bus.cout), 32'(e.cout));
                checkOutput("ovf", 32'(bus.ovf), 32'(e.ovf));
            end
        end
        prevDone = bus.done;
    end

    // Issue one request, scramble the operands after accept, and time the response.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        int lat;
        int busyCycles;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.sub   = sub;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.sub   = 1'($urandom);
        lat        = 0;
        busyCycles = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            if (bus.busy === 1'b1) busyCycles++;
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", 32'(lat), 32'(W));
        checkOutput("busyCycles", 32'(busyCycles), 32'(W));
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] pickOperand();
        logic [W-1:0] edgeVals [4];
        edgeVals[0] = '0;
        edgeVals[1] = {1'b0, {(W - 1){1'b1}}};
        edgeVals[2] = {1'b1, {(W - 1){1'b0}}};
        edgeVals[3] = '1;
        if ($urandom_range(0, 3) == 0) return edgeVals[$urandom_range(0, 3)];
        return W'($urandom);
    endfunction

    initial begin
        int cyc;
        int lastDone;
        int intervals;
        logic sawDone;

        compared   = 0;
        mismatched = 0;
        phase      = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.sub    = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        repeat (2) @(negedge clk);
        checkOutput("resetBusy", 32'(bus.busy), 32'(0));
        checkOutput("resetDone", 32'(bus.done), 32'(0));
        checkOutput("resetSum", 32'(bus.sum), 32'(0));
        checkOutput("resetCout", 32'(bus.cout), 32'(0));
        checkOutput("resetOvf", 32'(bus.ovf), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed add/sub cases");
        applyStimulus(8'h3C, 8'h0F, 1'b0);
        applyStimulus(8'hFF, 8'h01, 1'b0);
        applyStimulus(8'h7F, 8'h01, 1'b0);
        applyStimulus(8'h05, 8'h07, 1'b1);
        applyStimulus(8'h80, 8'h01, 1'b1);

        $display("[TB] abort by reset mid-run");
        bus.start = 1'b1;
        bus.a     = 8'h01;
        bus.b     = 8'h01;
        bus.sub   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("abortBusy", 32'(bus.busy), 32'(0));
        checkOutput("abortDone", 32'(bus.done), 32'(0));
        checkOutput("abortSum", 32'(bus.sum), 32'(0));
        sawDone = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done === 1'b1) sawDone = 1'b1;
        end
        checkOutput("abortNoDone", 32'(sawDone), 32'(0));
        applyStimulus(8'h01, 8'h01, 1'b0);

        $display("[TB] start held high with toggling operands");
        bus.start = 1'b1;
        lastDone  = -1;
        intervals = 0;
        for (cyc = 0; cyc < 62; cyc++) begin
            bus.a   = W'($urandom);
            bus.b   = W'($urandom);
            bus.sub = 1'($urandom);
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (lastDone >= 0) begin
                    checkOutput("doneInterval", 32'(cyc - lastDone), 32'(W + 2));
                    intervals++;
                end
                lastDone = cyc;
            end
        end
        checkOutput("intervalCount", 32'(intervals >= 4), 32'(1));
        bus.start = 1'b0;
        cyc = 0;
        while ((bus.busy === 1'b1 || bus.done === 1'b1) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("drainIdle", 32'(cyc < 20), 32'(1));
        @(negedge clk);

        $display("[TB] random operations");
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(pickOperand(), pickOperand(), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboardDrained", 32'(expQ.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, compared=%0d mismatched=%0d", compared, mismatched + 1);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
